// File: rtl/fetch16_unit.sv
// Instruction fetch engine: reads a big-endian 16-bit instruction as two byte
// reads over a req/ack port and presents it to decode over a valid/ready port.
module fetch16_unit #(
    parameter int unsigned     AW       = 16,
    parameter logic [AW-1:0]   RESET_PC = '0
) (
    input  logic          ck,
    input  logic          rst_n,
    input  logic          en,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [7:0]    mem_rdata,
    output logic [15:0]   ir,
    output logic [AW-1:0] ia,
    output logic          ir_valid,
    input  logic          ir_ready,
    output logic [AW-1:0] pc
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        REQ_LO = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [AW-1:0] PC_RST = RESET_PC & ~AW'(1);

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] r_ia;
    logic [15:0]   r_ir;
    logic [7:0]    r_hi;
    logic          w_req;
    logic          w_xfer;

    assign w_req  = (r_state == REQ_HI) || (r_state == REQ_LO);
    assign w_xfer = w_req && mem_ack;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (en)       w_next = REQ_HI;
            REQ_HI:  if (mem_ack)  w_next = REQ_LO;
            REQ_LO:  if (mem_ack)  w_next = HOLD;
            HOLD:    if (ir_ready) w_next = en ? REQ_HI : IDLE;
            default:               w_next = IDLE;
        endcase
        if (redirect) begin
            w_next = en ? REQ_HI : IDLE;
        end
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_pc    <= PC_RST;
            r_ia    <= '0;
            r_ir    <= '0;
            r_hi    <= '0;
        end else begin
            r_state <= w_next;
            if (redirect) begin
                r_pc <= redirect_pc & ~AW'(1);
            end else if (w_xfer && (r_state == REQ_HI)) begin
                // High byte is staged so ir keeps the last instruction until the pair completes.
                r_hi <= mem_rdata;
            end else if (w_xfer && (r_state == REQ_LO)) begin
                r_ir <= {r_hi, mem_rdata};
                r_ia <= r_pc;
                r_pc <= r_pc + AW'(2);
            end
        end
    end

    assign mem_req  = w_req;
    assign mem_addr = (r_state == REQ_LO) ? (r_pc + AW'(1)) :
                      (r_state == REQ_HI) ? r_pc : '0;
    assign ir_valid = (r_state == HOLD);
    assign ir       = r_ir;
    assign ia       = r_ia;
    assign pc       = r_pc;

endmodule

// File: tb/tb_fetch16_unit.sv
// Directed bench for fetch16_unit: byte memory model with programmable wait
// states and a scoreboard of expected (ia, ir) pairs.
module tb_fetch16_unit;

    logic        ck = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = '0;
    logic [15:0] ir;
    logic [15:0] ia;
    logic        ir_valid;
    logic        ir_ready = 1'b1;
    logic [15:0] pc;

    fetch16_unit #(.AW(16), .RESET_PC(16'h0000)) dut (
        .ck(ck), .rst_n(rst_n), .en(en), .redirect(redirect),
        .redirect_pc(redirect_pc), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ir(ir), .ia(ia),
        .ir_valid(ir_valid), .ir_ready(ir_ready), .pc(pc)
    );

    always #5 ck = ~ck;

    typedef struct packed {
        logic [15:0] ia;
        logic [15:0] ir;
    } exp_t;

    logic [7:0]  mem [0:65535];
    int unsigned waits = 0;
    int unsigned cnt = 0;
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;
    exp_t        sb[$];
    int unsigned dcyc[$];
    int unsigned en_cyc;

    always @(posedge ck) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory responder: acks after 'waits' stalled cycles per byte.
    initial begin
        forever begin
            @(negedge ck);
            if (mem_req) begin
                mem_rdata = mem[mem_addr];
                if (cnt >= waits) begin
                    mem_ack = 1'b1;
                    cnt     = 0;
                end else begin
                    mem_ack = 1'b0;
                    cnt++;
                end
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = '0;
                cnt       = 0;
            end
        end
    end

    // Monitor: scoreboard pops on accepted instructions, request stability through waits.
    logic        p_req = 1'b0, p_ack = 1'b0, p_redir = 1'b0, p_rstn = 1'b0;
    logic [15:0] p_addr = '0;
    initial begin
        exp_t e;
        forever begin
            @(negedge ck);
            #1;
            if (ir_valid && (ir_ready || redirect)) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk("ia", {16'h0, ia}, {16'h0, e.ia});
                    chk("ir", {16'h0, ir}, {16'h0, e.ir});
                    dcyc.push_back(cyc);
                end
            end
            if (p_req && !p_ack && !p_redir && p_rstn && rst_n) begin
                chk("req_hold", {15'h0, mem_req, mem_addr}, {15'h0, 1'b1, p_addr});
            end
            p_req   = mem_req;
            p_ack   = mem_ack;
            p_addr  = mem_addr;
            p_redir = redirect;
            p_rstn  = rst_n;
        end
    end

    task automatic do_reset();
        @(negedge ck);
        rst_n    = 1'b0;
        en       = 1'b0;
        redirect = 1'b0;
        ir_ready = 1'b1;
        repeat (2) @(negedge ck);
        rst_n = 1'b1;
        dcyc.delete();
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] i);
        exp_t e;
        e.ia = a;
        e.ir = i;
        sb.push_back(e);
    endtask

    task automatic wait_addr(input logic [15:0] a, input string tag);
        for (int n = 0; n < 200; n++) begin
            @(negedge ck);
            if (mem_req && mem_addr == a) break;
        end
        chk(tag, {15'h0, mem_req, mem_addr}, {15'h0, 1'b1, a});
    endtask

    task automatic drain(input string tag);
        for (int n = 0; n < 400 && sb.size() != 0; n++) @(negedge ck);
        chk(tag, 32'(sb.size()), 32'd0);
    endtask

    task automatic check_timing(input string tag, input int unsigned first, input int unsigned gap);
        chk({tag, "_n"}, 32'(dcyc.size()), 32'd4);
        if (dcyc.size() == 4) begin
            chk({tag, "_first"}, dcyc[0] - en_cyc, first);
            for (int i = 1; i < 4; i++) chk({tag, "_gap"}, dcyc[i] - dcyc[i-1], gap);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[0] = 8'h01; mem[1] = 8'ha2; mem[2] = 8'h04; mem[3] = 8'h26;
        mem[4] = 8'h0b; mem[5] = 8'hc9; mem[6] = 8'h08; mem[7] = 8'hef;
        mem[16'hfffe] = 8'h12; mem[16'hffff] = 8'h34;

        #1;
        chk("rst_req",   {31'h0, mem_req},  32'h0);
        chk("rst_valid", {31'h0, ir_valid}, 32'h0);
        chk("rst_pc",    {16'h0, pc},       32'h0);
        chk("rst_ir",    {16'h0, ir},       32'h0);
        chk("rst_ia",    {16'h0, ia},       32'h0);
        chk("rst_addr",  {16'h0, mem_addr}, 32'h0);
        repeat (2) @(negedge ck);
        rst_n = 1'b1;

        // 1: zero-wait streaming
        waits = 0;
        push(16'h0000, 16'h01a2); push(16'h0002, 16'h0426);
        push(16'h0004, 16'h0bc9); push(16'h0006, 16'h08ef);
        @(negedge ck);
        en = 1'b1;
        en_cyc = cyc;
        drain("t1_drain");
        check_timing("t1", 3, 3);

        // 2: two wait states per byte
        do_reset();
        waits = 2;
        push(16'h0000, 16'h01a2); push(16'h0002, 16'h0426);
        push(16'h0004, 16'h0bc9); push(16'h0006, 16'h08ef);
        @(negedge ck);
        en = 1'b1;
        en_cyc = cyc;
        drain("t2_drain");
        check_timing("t2", 7, 7);

        // 3: decode back-pressure
        do_reset();
        waits = 0;
        push(16'h0000, 16'h01a2); push(16'h0002, 16'h0426); push(16'h0004, 16'h0bc9);
        @(negedge ck);
        en = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge ck);
            if (ir_valid && ia == 16'h0002) break;
        end
        ir_ready = 1'b0;
        chk("t3_reach", {15'h0, ir_valid, ia}, {15'h0, 1'b1, 16'h0002});
        repeat (5) begin
            @(negedge ck);
            #1;
            chk("t3_valid", {31'h0, ir_valid}, 32'h1);
            chk("t3_ir",    {16'h0, ir},       32'h0426);
            chk("t3_ia",    {16'h0, ia},       32'h0002);
            chk("t3_req",   {31'h0, mem_req},  32'h0);
            chk("t3_pc",    {16'h0, pc},       32'h0004);
        end
        @(negedge ck);
        ir_ready = 1'b1;
        drain("t3_drain");

        // 4: redirect during the low-byte read of ia=2
        do_reset();
        waits = 0;
        push(16'h0000, 16'h01a2); push(16'h0004, 16'h0bc9); push(16'h0006, 16'h08ef);
        @(negedge ck);
        en = 1'b1;
        wait_addr(16'h0003, "t4_reach");
        redirect    = 1'b1;
        redirect_pc = 16'h0005;
        @(negedge ck);
        redirect = 1'b0;
        #1;
        chk("t4_pc", {16'h0, pc}, 32'h0004);
        drain("t4_drain");

        // 5: address wrap at top of memory
        do_reset();
        waits = 0;
        push(16'hfffe, 16'h1234); push(16'h0000, 16'h01a2);
        @(negedge ck);
        en          = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'hfffe;
        @(negedge ck);
        redirect = 1'b0;
        drain("t5_drain");

        // 6: asynchronous reset mid-wait in the low-byte read
        do_reset();
        waits = 2;
        push(16'h0000, 16'h01a2);
        @(negedge ck);
        en = 1'b1;
        wait_addr(16'h0003, "t6_reach");
        rst_n = 1'b0;
        #1;
        chk("t6_req",   {31'h0, mem_req},  32'h0);
        chk("t6_valid", {31'h0, ir_valid}, 32'h0);
        chk("t6_pc",    {16'h0, pc},       32'h0);
        chk("t6_sb",    32'(sb.size()),    32'd0);
        repeat (2) @(negedge ck);
        rst_n = 1'b1;
        push(16'h0000, 16'h01a2);
        drain("t6_drain");

        @(negedge ck);
        en = 1'b0;
        repeat (4) @(negedge ck);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
